// File: rtl/axis_frame_trailer.sv
// 64-bit AXI-Stream pass-through that appends a {magic, beat count, word sum} trailer beat to every frame.
// Optional ACCEL_TRAILER_BYTESWAP_EN: byte-reverse data beats before output and accumulation.
module axis_frame_trailer #(
    parameter int          C_AXIS_DATA_WIDTH = 64,
    parameter logic [15:0] C_TRAILER_MAGIC   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         frame_done,
    output logic [31:0]                  frame_count
);
    // state | meaning
    // PASS  | forwarding data beats, accumulating sum/cnt
    // TRAIL | last beat taken, waiting for skid/output room to load trailer
    // DRAIN | trailer on the bus, waiting for its handshake
    typedef enum logic [1:0] {PASS, TRAIL, DRAIN} state_t;

    state_t                       state, state_nxt;
    logic [C_AXIS_DATA_WIDTH-1:0] out_data, skid_data, beat_data;
    logic                         out_valid, out_last, skid_valid;
    logic [31:0]                  sum;
    logic [15:0]                  cnt;
    logic                         accept, out_free, load_trailer, trailer_hs;

`ifdef ACCEL_TRAILER_BYTESWAP_EN
    function automatic logic [63:0] byte_swap(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
        return r;
    endfunction
    assign beat_data = byte_swap(s_axis_tdata);
`else
    assign beat_data = s_axis_tdata;
`endif

    // Ready depends only on registered state, never on m_axis_tready.
    assign s_axis_tready = aresetn && (state == PASS) && !skid_valid;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign out_free      = !out_valid || m_axis_tready;

    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;
    assign m_axis_tvalid = out_valid;

    always_comb begin
        state_nxt    = state;
        load_trailer = 1'b0;
        trailer_hs   = 1'b0;
        case (state)
            PASS: begin
                if (accept && s_axis_tlast) state_nxt = TRAIL;
            end
            TRAIL: begin
                if (!skid_valid && out_free) begin
                    load_trailer = 1'b1;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && m_axis_tready) begin
                    trailer_hs = 1'b1;
                    state_nxt  = PASS;
                end
            end
            default: state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) state <= PASS;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            out_data    <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            skid_data   <= '0;
            skid_valid  <= 1'b0;
            sum         <= '0;
            cnt         <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= trailer_hs;
            if (out_free) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_last   <= 1'b0;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_data  <= beat_data;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                end else if (load_trailer) begin
                    out_data  <= {C_TRAILER_MAGIC, cnt, sum};
                    out_last  <= 1'b1;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_data  <= beat_data;
                skid_valid <= 1'b1;
            end

            if (trailer_hs) begin
                sum         <= '0;
                cnt         <= '0;
                frame_count <= frame_count + 32'd1;
            end else if (accept) begin
                sum <= sum + beat_data[31:0] + beat_data[63:32];
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_frame_trailer.sv
// Directed bench for axis_frame_trailer: scoreboard of expected output beats filled as input beats are accepted.
module tb_axis_frame_trailer;
    localparam logic [15:0] MAGIC = 16'hACE1;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        frame_done;
    logic [31:0] frame_count;

    logic        ready_dir = 1'b1;
    logic        rnd_en = 1'b0;
    logic        rnd_bit = 1'b1;
    assign m_axis_tready = rnd_en ? rnd_bit : ready_dir;

    axis_frame_trailer dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .frame_done   (frame_done),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    int          n_checks = 0;
    int          n_fails = 0;
    logic [64:0] sb[$];
    logic [31:0] m_sum = '0;
    logic [15:0] m_cnt = '0;
    int          frames_sent = 0;
    int          done_cnt = 0;
    int          falls = 0;
    logic [63:0] last_trailer = '0;
    logic [63:0] last_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input logic [63:0] d);
        logic [63:0] r;
`ifdef ACCEL_TRAILER_BYTESWAP_EN
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
`else
        r = d;
`endif
        return r;
    endfunction

    // Output monitor, sampled on the falling edge.
    logic        expect_done = 1'b0;
    logic        hold_pend = 1'b0;
    logic [63:0] hold_data = '0;
    logic        hold_last = 1'b0;
    logic        prev_sready = 1'b0;
    always @(negedge clk) begin
        if (!aresetn) begin
            expect_done = 1'b0;
            hold_pend   = 1'b0;
        end else begin
            check("frame_done", 64'(frame_done), 64'(expect_done));
            if (frame_done) done_cnt++;
            expect_done = 1'b0;
            if (hold_pend) begin
                check("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check("hold_data", m_axis_tdata, hold_data);
                check("hold_last", 64'(m_axis_tlast), 64'(hold_last));
            end
            hold_pend = m_axis_tvalid && !m_axis_tready;
            hold_data = m_axis_tdata;
            hold_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {63'd0, m_axis_tlast}, 64'd2);
                end else begin
                    logic [64:0] e;
                    e = sb.pop_front();
                    check("out_data", m_axis_tdata, e[63:0]);
                    check("out_last", 64'(m_axis_tlast), 64'(e[64]));
                    if (e[64]) begin
                        expect_done  = 1'b1;
                        last_trailer = m_axis_tdata;
                    end else begin
                        last_data = m_axis_tdata;
                    end
                end
            end
        end
        if (prev_sready && !s_axis_tready) falls++;
        prev_sready = s_axis_tready;
    end

    task automatic send_beat(input logic [63:0] d, input logic l);
        logic [63:0] e;
        bit          hs;
        int          t;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 2000);
        check("send_timeout", 64'(hs), 64'd1);
        e = exp_data(d);
        sb.push_back({1'b0, e});
        m_sum = m_sum + e[31:0] + e[63:32];
        m_cnt = m_cnt + 16'd1;
        if (l) begin
            sb.push_back({1'b1, MAGIC, m_cnt, m_sum});
            m_sum = '0;
            m_cnt = '0;
            frames_sent++;
        end
    endtask

    task automatic idle_input();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_empty();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_data", m_axis_tdata, 64'd0);
        check("rst_m_last", 64'(m_axis_tlast), 64'd0);
        check("rst_s_ready", 64'(s_axis_tready), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        aresetn = 1'b1;
        #1;
        check("ready_after_reset", 64'(s_axis_tready), 64'd1);

        // Three-beat frame, downstream always ready.
        send_beat(64'h00000001_00000002, 1'b0);
        send_beat(64'h00000003_00000004, 1'b0);
        send_beat(64'h00000005_00000006, 1'b1);
        idle_input();
        wait_empty();
        check("fc_frame1", 64'(frame_count), 64'd1);
        check("done_frame1", 64'(done_cnt), 64'd1);
`ifndef ACCEL_TRAILER_BYTESWAP_EN
        check("trailer_frame1", last_trailer, 64'hACE1_0003_00000015);
`endif

        // Single-beat frame whose sum wraps.
        send_beat(64'hFFFFFFFF_00000001, 1'b1);
        idle_input();
        wait_empty();
`ifndef ACCEL_TRAILER_BYTESWAP_EN
        check("trailer_single", last_trailer, 64'hACE1_0001_00000000);
`endif
        check("fc_single", 64'(frame_count), 64'd2);

        // Fill output register and skid with downstream stalled.
        ready_dir = 1'b0;
        send_beat(64'h11111111_22222222, 1'b0);
        send_beat(64'h33333333_44444444, 1'b0);
        idle_input();
        @(posedge clk);
        #1;
        check("stall_ready_low", 64'(s_axis_tready), 64'd0);
        ready_dir = 1'b1;
        send_beat(64'h55555555_66666666, 1'b1);
        idle_input();
        wait_empty();
        check("trailer_stall_cnt", 64'(last_trailer[47:32]), 64'd3);

        // 100-beat frame with random backpressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 100; i++) send_beat({$urandom, $urandom}, i == 99);
        idle_input();
        wait_empty();
        rnd_en = 1'b0;
        check("trailer_bp_cnt", 64'(last_trailer[47:32]), 64'd100);
        check("fc_bp", 64'(frame_count), 64'd4);

        // Two back-to-back 2-beat frames.
        f0 = falls;
        send_beat(64'hA0A0A0A0_00000001, 1'b0);
        send_beat(64'hA0A0A0A0_00000002, 1'b1);
        send_beat(64'hB0B0B0B0_00000003, 1'b0);
        send_beat(64'hB0B0B0B0_00000004, 1'b1);
        idle_input();
        wait_empty();
        check("b2b_bubbles", 64'(falls - f0), 64'd2);
        check("fc_b2b", 64'(frame_count), 64'd6);

        // Reset after 2 of 4 beats; partial frame must vanish.
        send_beat(64'hC0C0C0C0_00000001, 1'b0);
        send_beat(64'hC0C0C0C0_00000002, 1'b0);
        idle_input();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b0;
        sb.delete();
        m_sum = '0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        check_reset_vals();
        aresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_trailer_after_rst", 64'(m_axis_tvalid), 64'd0);
        send_beat(64'h00000007_00000008, 1'b1);
        idle_input();
        wait_empty();
        check("trailer_post_rst_cnt", 64'(last_trailer[47:32]), 64'd1);
        check("fc_post_rst", 64'(frame_count), 64'd1);

`ifdef ACCEL_TRAILER_BYTESWAP_EN
        send_beat(64'h01020304_05060708, 1'b1);
        idle_input();
        wait_empty();
        check("swap_data", last_data, 64'h08070605_04030201);
        check("swap_sum", 64'(last_trailer[31:0]), 64'h0C0A0806);
`endif

        check("done_total", 64'(done_cnt), 64'(frames_sent));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
